// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction prefetch queue between instruction memory and decode.
//   Issues in-order fetch requests on a valid/ready port. Up to MAX_OUTSTANDING
//   requests may be in flight at once. Responses return in request order and are
//   buffered as {pc, pc+4, instr} entries in a DEPTH-entry circular queue. The
//   queue head is presented to decode with valid/ready. An execute-stage redirect
//   flushes the queue, restarts fetch at the target and discards the responses
//   that are still in flight.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   redirect_valid/pc taken branch/jump from execute and its target
//   imem_req_*        fetch request port (valid/ready, addr)
//   imem_rsp_*        in-order fetch response (valid, data)
//   dec_*             queue head to decode (valid/ready, pc, pc+4, instr)
//   count             current queue occupancy
module fetch_queue #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [ADDRESS_WIDTH-1:0] dec_pc,
    output logic [ADDRESS_WIDTH-1:0] dec_pc_plus4,
    output logic [DATA_WIDTH-1:0]    dec_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Queue storage
    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc4_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];

    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         occ;

    // Fetch-side state
    logic [ADDRESS_WIDTH-1:0] fetch_pc;     // next address to request
    logic [ADDRESS_WIDTH-1:0] rsp_pc;       // pc of the next response to be kept
    logic [CNT_W-1:0]         outstanding;  // accepted but unanswered requests
    logic [CNT_W-1:0]         drop_cnt;     // stale responses still to discard

    logic [CNT_W:0]           in_use;
    logic                     credit_ok;
    logic                     req_valid_int;
    logic                     req_fire;
    logic                     rsp_fire;
    logic                     head_valid;
    logic                     pop;
    logic                     push;

    // A slot is reserved for every outstanding request, so a response can
    // always be pushed without back-pressure on the response path.
    always_comb begin
        in_use        = {1'b0, occ} + {1'b0, outstanding};
        credit_ok     = (in_use < (CNT_W + 1)'(DEPTH))
                        && (outstanding < CNT_W'(MAX_OUTSTANDING));
        req_valid_int = !rst && !redirect_valid && credit_ok;
        req_fire      = req_valid_int && imem_req_ready;
        rsp_fire      = imem_rsp_valid && (outstanding != '0);
        head_valid    = (occ != '0);
        pop           = !rst && !redirect_valid && head_valid && dec_ready;
        push          = rsp_fire && !redirect_valid && (drop_cnt == '0);
    end

    // Outputs are forced to zero while reset is asserted.
    always_comb begin
        imem_req_valid = req_valid_int;
        imem_req_addr  = rst ? '0 : fetch_pc;
        dec_valid      = !rst && !redirect_valid && head_valid;
        dec_pc         = rst ? '0 : pc_mem[rd_ptr];
        dec_pc_plus4   = rst ? '0 : pc4_mem[rd_ptr];
        dec_instr      = rst ? '0 : instr_mem[rd_ptr];
        count          = rst ? '0 : occ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                pc4_mem[i]   <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Every request still unanswered after this edge belongs to the
            // old path; a response arriving now is discarded as well.
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            drop_cnt    <= outstanding - CNT_W'(rsp_fire);
            outstanding <= outstanding - CNT_W'(rsp_fire);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
            end

            if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end

            if (push) begin
                pc_mem[wr_ptr]    <= rsp_pc;
                pc4_mem[wr_ptr]   <= rsp_pc + ADDRESS_WIDTH'(4);
                instr_mem[wr_ptr] <= imem_rsp_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                rsp_pc            <= rsp_pc + ADDRESS_WIDTH'(4);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            occ         <= occ + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        end
    end

endmodule
